// File: rtl/seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seg_scan_ctrl
//   Display scheduler for a 4-digit, active-low 7-segment panel.
//   A 14-bit binary value arrives over a valid/ready handshake. It is
//   saturated to 9999 and converted to BCD one bit per clock (shift-add-3).
//   The finished BCD word is committed to the display register in a single
//   clock. The four anodes are then time-multiplexed at SCAN_DIV clocks per
//   digit, and each digit can blink with a half-period of BLINK_FRAMES frames.
//
// Parameters
//   SCAN_DIV      clocks each digit stays lit (1..65535)
//   BLINK_FRAMES  full 4-digit frames per blink half-period (1..255)
//
// Ports
//   clk          system clock
//   rst_n        asynchronous, active-low reset
//   value_in     binary value to display
//   value_valid  value_in is offered this cycle
//   value_ready  block can accept a value (converter idle)
//   blink_mask   bit i = 1 makes the digit on an[i] blink
//   busy         conversion shift phase in progress
//   an           anodes, active-low; an[3] = thousands .. an[0] = units
//   seg          segments, active-low, {g,f,e,d,c,b,a}
//
// Build option
//   SEG_LZ_BLANK_EN  when defined, leading zeros on the thousands, hundreds
//                    and tens digits are blanked. The units digit is always
//                    shown.
// -----------------------------------------------------------------------------
module seg_scan_ctrl #(
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned BLINK_FRAMES = 125
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [13:0] value_in,
  input  logic        value_valid,
  output logic        value_ready,
  input  logic [3:0]  blink_mask,
  output logic        busy,
  output logic [3:0]  an,
  output logic [6:0]  seg
);

  localparam logic [1:0]  ST_IDLE    = 2'd0;
  localparam logic [1:0]  ST_SHIFT   = 2'd1;
  localparam logic [1:0]  ST_COMMIT  = 2'd2;

  localparam logic [15:0] SCAN_LAST  = 16'(SCAN_DIV - 1);
  localparam logic [7:0]  BLINK_LAST = 8'(BLINK_FRAMES - 1);
  localparam logic [13:0] VALUE_MAX  = 14'd9999;
  localparam logic [6:0]  SEG_OFF    = 7'b1111111;

  // Segment patterns for the digits 0..9. Any other code turns the digit off.
  function automatic logic [6:0] seg_encode(input logic [3:0] digit);
    case (digit)
      4'd0:    seg_encode = 7'b1000000;
      4'd1:    seg_encode = 7'b1111001;
      4'd2:    seg_encode = 7'b0100100;
      4'd3:    seg_encode = 7'b0110000;
      4'd4:    seg_encode = 7'b0011001;
      4'd5:    seg_encode = 7'b0010010;
      4'd6:    seg_encode = 7'b0000010;
      4'd7:    seg_encode = 7'b1111000;
      4'd8:    seg_encode = 7'b0000000;
      4'd9:    seg_encode = 7'b0010000;
      default: seg_encode = SEG_OFF;
    endcase
  endfunction

  // Add 3 to every BCD nibble that is 5 or more, so that the next left shift
  // carries correctly into the following decade.
  function automatic logic [15:0] bcd_adjust(input logic [15:0] bcd);
    logic [15:0] res;
    for (int i = 0; i < 4; i++) begin
      res[4*i +: 4] = (bcd[4*i +: 4] >= 4'd5) ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
    end
    return res;
  endfunction

  // ---------------------------------------------------------------------------
  // Conversion FSM
  // ---------------------------------------------------------------------------
  logic [1:0]  state;
  logic [29:0] dd_reg;     // {bcd[15:0], binary[13:0]} double-dabble register
  logic [29:0] dd_adj;
  logic [3:0]  shift_cnt;
  logic [15:0] disp_bcd;   // committed display value; changes only in COMMIT

  assign dd_adj      = {bcd_adjust(dd_reg[29:14]), dd_reg[13:0]};
  assign value_ready = (state == ST_IDLE);
  assign busy        = (state == ST_SHIFT);

  // NOTE: state registers use non-blocking assignments so that every flop
  // samples the values from before the clock edge, whatever order the
  // statements appear in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      dd_reg    <= '0;
      shift_cnt <= '0;
      disp_bcd  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (value_valid) begin
            dd_reg    <= {16'd0, (value_in > VALUE_MAX) ? VALUE_MAX : value_in};
            shift_cnt <= '0;
            state     <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          dd_reg    <= {dd_adj[28:0], 1'b0};
          shift_cnt <= shift_cnt + 4'd1;
          if (shift_cnt == 4'd13) state <= ST_COMMIT;
        end
        ST_COMMIT: begin
          disp_bcd <= dd_reg[29:14];
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Scan timing: digit index, frame counter, blink phase
  // ---------------------------------------------------------------------------
  logic [15:0] scan_cnt;
  logic [1:0]  digit_idx;
  logic [7:0]  frame_cnt;
  logic        blink_phase;
  logic        refresh;    // the index moved last clock, so reload an/seg
  logic        scan_wrap;

  assign scan_wrap = (scan_cnt == SCAN_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt    <= '0;
      digit_idx   <= '0;
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
      refresh     <= 1'b1;  // light the thousands digit on the first clock
    end else begin
      refresh <= scan_wrap;
      if (scan_wrap) begin
        scan_cnt  <= '0;
        digit_idx <= digit_idx + 2'd1;
        if (digit_idx == 2'd3) begin
          if (frame_cnt == BLINK_LAST) begin
            frame_cnt   <= '0;
            blink_phase <= ~blink_phase;
          end else begin
            frame_cnt <= frame_cnt + 8'd1;
          end
        end
      end else begin
        scan_cnt <= scan_cnt + 16'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Digit selection and registered outputs
  // ---------------------------------------------------------------------------
  logic [3:0] an_next;
  logic [3:0] digit;
  logic       lz_blank;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case can leave a value held and infer a latch.
  always_comb begin
    an_next  = 4'b1111;
    digit    = 4'd0;
    lz_blank = 1'b0;
    case (digit_idx)
      2'd0: begin
        an_next  = 4'b0111;
        digit    = disp_bcd[15:12];
        lz_blank = (disp_bcd[15:12] == 4'd0);
      end
      2'd1: begin
        an_next  = 4'b1011;
        digit    = disp_bcd[11:8];
        lz_blank = (disp_bcd[15:8] == 8'd0);
      end
      2'd2: begin
        an_next  = 4'b1101;
        digit    = disp_bcd[7:4];
        lz_blank = (disp_bcd[15:4] == 12'd0);
      end
      default: begin
        an_next  = 4'b1110;
        digit    = disp_bcd[3:0];
        lz_blank = 1'b0;
      end
    endcase
`ifndef SEG_LZ_BLANK_EN
    lz_blank = 1'b0;
`endif
  end

  // an and seg load together, so the panel never pairs one digit's anode
  // with another digit's segments. The blink mask is sampled at that moment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an  <= 4'b1111;
      seg <= SEG_OFF;
    end else if (refresh) begin
      an <= an_next;
      if ((blink_phase && |(blink_mask & ~an_next)) || lz_blank) seg <= SEG_OFF;
      else                                                      seg <= seg_encode(digit);
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seg_scan_ctrl
//   Three instances of seg_scan_ctrl share one stimulus stream:
//     dut 0: SCAN_DIV=4, BLINK_FRAMES=2
//     dut 1: SCAN_DIV=2, BLINK_FRAMES=2
//     dut 2: SCAN_DIV=1, BLINK_FRAMES=1
//   A reference model works out each instance's expected an/seg from the
//   number of clocks since reset. It also tracks the accept/commit timeline
//   of the converter. A scoreboard compares all outputs on every falling edge.
//   Directed sequences and a table of values cover latency, saturation,
//   held-valid, mid-run reset and blinking. Random traffic follows.
// -----------------------------------------------------------------------------
module tb_seg_scan_ctrl;

  localparam int N_DUT = 3;

  logic        clk         = 1'b0;
  logic        rst_n       = 1'b1;
  logic [13:0] value_in    = '0;
  logic        value_valid = 1'b0;
  logic [3:0]  blink_mask  = '0;

  logic [3:0]  an_o  [N_DUT];
  logic [6:0]  seg_o [N_DUT];
  logic        rdy   [N_DUT];
  logic        bsy   [N_DUT];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  seg_scan_ctrl #(.SCAN_DIV(4), .BLINK_FRAMES(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .value_in(value_in), .value_valid(value_valid),
    .value_ready(rdy[0]), .blink_mask(blink_mask), .busy(bsy[0]),
    .an(an_o[0]), .seg(seg_o[0]));

  seg_scan_ctrl #(.SCAN_DIV(2), .BLINK_FRAMES(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .value_in(value_in), .value_valid(value_valid),
    .value_ready(rdy[1]), .blink_mask(blink_mask), .busy(bsy[1]),
    .an(an_o[1]), .seg(seg_o[1]));

  seg_scan_ctrl #(.SCAN_DIV(1), .BLINK_FRAMES(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .value_in(value_in), .value_valid(value_valid),
    .value_ready(rdy[2]), .blink_mask(blink_mask), .busy(bsy[2]),
    .an(an_o[2]), .seg(seg_o[2]));

  function automatic int div_of(input int i);
    case (i)
      0:       return 4;
      1:       return 2;
      default: return 1;
    endcase
  endfunction

  function automatic int bf_of(input int i);
    return (i == 2) ? 1 : 2;
  endfunction

  function automatic logic [6:0] seg_code(input int d);
    case (d)
      0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
      4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
      8: return 7'h00;  9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  // Position d counts from the left (0 = thousands).
  function automatic bit lz_hidden(input int unsigned v, input int d);
`ifdef SEG_LZ_BLANK_EN
    if (d == 0) return v < 1000;
    if (d == 1) return v < 100;
    if (d == 2) return v < 10;
`endif
    return 1'b0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  int          edge_n   = 0;   // rising edges since reset released
  int          conv_age = -1;  // edges since accept, -1 when idle
  int unsigned pend_val = 0;
  int unsigned disp_val = 0;
  logic [3:0]  exp_an  [N_DUT];
  logic [6:0]  exp_seg [N_DUT];

  initial begin
    int slot, d, p, digit;
    bit phase;
    for (int i = 0; i < N_DUT; i++) begin
      exp_an[i]  = 4'hF;
      exp_seg[i] = 7'h7F;
    end
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        edge_n   = 0;
        conv_age = -1;
        disp_val = 0;
        for (int i = 0; i < N_DUT; i++) begin
          exp_an[i]  = 4'hF;
          exp_seg[i] = 7'h7F;
        end
      end else begin
        edge_n++;
        // Slot s is shown after edges s*DIV+1 .. (s+1)*DIV and is loaded from
        // the display value as it stood just before edge s*DIV+1.
        for (int i = 0; i < N_DUT; i++) begin
          if ((edge_n - 1) % div_of(i) == 0) begin
            slot  = (edge_n - 1) / div_of(i);
            d     = slot % 4;
            phase = ((slot / 4) / bf_of(i)) % 2 == 1;
            p     = (d == 0) ? 1000 : (d == 1) ? 100 : (d == 2) ? 10 : 1;
            digit = int'(disp_val) / p % 10;
            exp_an[i]  = ~(4'b1000 >> d);
            exp_seg[i] = ((phase && blink_mask[3-d]) || lz_hidden(disp_val, d))
                         ? 7'h7F : seg_code(digit);
          end
        end
        if (conv_age >= 0) begin
          conv_age++;
          if (conv_age == 15) begin
            disp_val = pend_val;
            conv_age = -1;
          end
        end else if (value_valid) begin
          pend_val = (value_in > 14'd9999) ? 9999 : int'(value_in);
          conv_age = 0;
        end
      end
    end
  end

  // Scoreboard: every output of every instance on every falling edge.
  initial forever begin
    @(negedge clk);
    for (int i = 0; i < N_DUT; i++) begin
      check($sformatf("dut%0d an", i),    an_o[i],  exp_an[i]);
      check($sformatf("dut%0d seg", i),   seg_o[i], exp_seg[i]);
      check($sformatf("dut%0d ready", i), rdy[i],   conv_age == -1);
      check($sformatf("dut%0d busy", i),  bsy[i],   conv_age >= 0 && conv_age <= 13);
    end
  end

  // ---------------------------------------------------------------------------
  // Directed helpers
  // ---------------------------------------------------------------------------
  logic [6:0] frame_seg [4];

  // Present v and keep it valid until a ready cycle. The task returns on the
  // falling edge just after the accepting clock, with valid dropped.
  task automatic offer(input logic [13:0] v);
    value_in    = v;
    value_valid = 1'b1;
    for (int c = 0; c < 40 && !rdy[0]; c++) @(negedge clk);
    check("offer ready", rdy[0], 1'b1);
    @(negedge clk);
    value_valid = 1'b0;
  endtask

  task automatic wait_ready();
    for (int c = 0; c < 40 && !rdy[0]; c++) @(negedge clk);
    check("wait ready", rdy[0], 1'b1);
  endtask

  // Capture one whole frame of dut 0 (4 digits x 4 clocks).
  task automatic read_frame();
    for (int d = 0; d < 4; d++) frame_seg[d] = 7'bx;
    repeat (16) begin
      @(negedge clk);
      for (int d = 0; d < 4; d++)
        if (an_o[0] == ~(4'b1000 >> d)) frame_seg[d] = seg_o[0];
    end
  endtask

  task automatic check_frame(input string tag, input logic [15:0] bcd);
    int unsigned v;
    logic [6:0] e;
    v = bcd[15:12] * 1000 + bcd[11:8] * 100 + bcd[7:4] * 10 + bcd[3:0];
    for (int d = 0; d < 4; d++) begin
      e = lz_hidden(v, d) ? 7'h7F : seg_code(int'(bcd[4*(3-d) +: 4]));
      check($sformatf("%s digit%0d", tag, d), frame_seg[d], e);
    end
  endtask

  typedef struct {
    logic [13:0] value;
    logic [15:0] bcd;
  } vec_t;

  vec_t vecs [9];

  initial begin
    int cyc, bcnt, shown, blank, bad;
    logic last_rdy;

    vecs[0] = '{14'd16383, 16'h9999};
    vecs[1] = '{14'd9999,  16'h9999};
    vecs[2] = '{14'd10000, 16'h9999};
    vecs[3] = '{14'd0,     16'h0000};
    vecs[4] = '{14'd7,     16'h0007};
    vecs[5] = '{14'd1005,  16'h1005};
    vecs[6] = '{14'd42,    16'h0042};
    vecs[7] = '{14'd5,     16'h0005};
    vecs[8] = '{14'd980,   16'h0980};

    // Reset, then the first frame shows the reset value.
    #1 rst_n = 1'b0;
    @(negedge clk);
    for (int i = 0; i < N_DUT; i++) begin
      check("reset an",    an_o[i],  4'hF);
      check("reset seg",   seg_o[i], 7'h7F);
      check("reset ready", rdy[i],   1'b1);
      check("reset busy",  bsy[i],   1'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    read_frame();
    check_frame("post-reset", 16'h0000);

    // Latency of 1234: ready drops, 14 busy clocks, commit on clock 15.
    offer(14'd1234);
    check("ready drops after accept", rdy[0], 1'b0);
    cyc  = 0;
    bcnt = 0;
    while (!rdy[0] && cyc < 40) begin
      cyc++;
      bcnt += int'(bsy[0]);
      @(negedge clk);
    end
    check("accept-to-idle clocks", cyc, 15);
    check("busy clocks", bcnt, 14);
    repeat (4) @(negedge clk);
    read_frame();
    check_frame("1234", 16'h1234);

    // Conversion table: saturation, boundaries, leading zeros.
    for (int k = 0; k < 9; k++) begin
      offer(vecs[k].value);
      wait_ready();
      repeat (4) @(negedge clk);
      read_frame();
      check_frame($sformatf("vec%0d", k), vecs[k].bcd);
    end

    // 5678 is held valid during the conversion of 1111 and is taken in the
    // idle cycle right after the commit.
    value_in    = 14'd1111;
    value_valid = 1'b1;
    for (int c = 0; c < 40 && !rdy[0]; c++) @(negedge clk);
    @(negedge clk);
    value_in = 14'd5678;
    cyc = 0;
    while (!rdy[0] && cyc < 40) begin
      cyc++;
      @(negedge clk);
    end
    check("held-valid first conversion clocks", cyc, 15);
    @(negedge clk);
    check("held value accepted after commit", rdy[0], 1'b0);
    value_valid = 1'b0;
    wait_ready();
    repeat (4) @(negedge clk);
    read_frame();
    check_frame("5678", 16'h5678);

    // Reset in the middle of a conversion acts at once, between clock edges.
    offer(14'd4321);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < N_DUT; i++) begin
      check("async reset an",    an_o[i],  4'hF);
      check("async reset seg",   seg_o[i], 7'h7F);
      check("async reset ready", rdy[i],   1'b1);
      check("async reset busy",  bsy[i],   1'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    read_frame();
    check_frame("after mid-run reset", 16'h0000);

    // Blinking on dut 1 (2 clocks/digit, 2 frames per half-period): over 64
    // clocks the units digit is lit 8 clocks and blank 8 clocks.
    blink_mask = 4'b0001;
    offer(14'd8888);
    wait_ready();
    repeat (8) @(negedge clk);
    shown = 0;
    blank = 0;
    bad   = 0;
    repeat (64) begin
      @(negedge clk);
      if (an_o[1] == 4'b1110) begin
        if (seg_o[1] == 7'h00) shown++;
        else if (seg_o[1] == 7'h7F) blank++;
        else bad++;
      end else if (seg_o[1] != 7'h00) begin
        bad++;
      end
    end
    check("blink units shown clocks", shown, 8);
    check("blink units blank clocks", blank, 8);
    check("blink other digits steady", bad, 0);
    blink_mask = 4'b0000;

    // Random traffic. The producer holds value/valid until a ready cycle.
    last_rdy = 1'b0;
    for (int k = 0; k < 1500; k++) begin
      @(negedge clk);
      if (value_valid && last_rdy) value_valid = 1'b0;
      if (!value_valid && $urandom_range(0, 3) == 0) begin
        value_valid = 1'b1;
        value_in = ($urandom_range(0, 1) == 1) ? 14'($urandom_range(0, 16383))
                                               : 14'($urandom_range(0, 120));
      end
      if ($urandom_range(0, 40) == 0) blink_mask = 4'($urandom);
      last_rdy = rdy[0];
    end
    value_valid = 1'b0;
    wait_ready();
    repeat (20) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
